// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } state_e;

    localparam int unsigned MidTick   = 7;   // last tick before mid start bit
    localparam int unsigned BitTick   = 15;  // last tick of one 16x bit period
    localparam int unsigned DefDbit   = 8;
    localparam int unsigned DefSbTick = 16;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input.
module rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    // Both stages reset high so the line looks idle straight out of reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= 1'b1;
            q      <= 1'b1;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled, centre-sampling deserialiser with
// one-cycle done / framing-error pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned DBIT    = DefDbit,
    parameter int unsigned SB_TICK = DefSbTick
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done,
    output logic            frame_err
);

    localparam int unsigned SW = $clog2(SB_TICK);
    localparam int unsigned NW = $clog2(DBIT);

    state_e            state_q, state_d;
    logic [SW-1:0]     s_q, s_d;
    logic [NW-1:0]     n_q, n_d;
    logic [DBIT-1:0]   sh_q, sh_d;
    logic [DBIT-1:0]   dout_q, dout_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              rx_s;

    rx_sync u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            s_q     <= '0;
            n_q     <= '0;
            sh_q    <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        sh_d    = sh_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Start edge is taken immediately; timing begins from here.
                if (!rx_s) begin
                    state_d = StStart;
                    s_d     = '0;
                end
            end
            StStart: begin
                if (s_tick) begin
                    if (s_q == SW'(MidTick)) begin
                        if (!rx_s) begin
                            state_d = StData;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            StData: begin
                if (s_tick) begin
                    if (s_q == SW'(BitTick)) begin
                        sh_d = {rx_s, sh_q[DBIT-1:1]};
                        s_d  = '0;
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = StStop;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            StStop: begin
                if (s_tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        state_d = StIdle;
                        if (rx_s) begin
                            dout_d = sh_q;
                            done_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign dout      = dout_q;
    assign rx_done   = done_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (8N1 instance plus a 7-bit, 2-stop instance).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx1 = 1'b1;
    logic       rx2 = 1'b1;
    logic [7:0] dout1;
    logic [6:0] dout2;
    logic       done1, err1, done2, err2;

    int n_checks = 0;
    int n_pass   = 0;

    int unsigned cyc = 0;
    int unsigned edge_cyc = 0;
    logic [1:0]  tick_div = 2'd0;

    int          done1_cnt = 0, err1_cnt = 0, done2_cnt = 0, err2_cnt = 0, viol = 0;
    int unsigned done1_cyc = 0, done2_cyc = 0;
    logic        prev1 = 1'b0, prev2 = 1'b0;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_tick    (s_tick),
        .rx        (rx1),
        .dout      (dout1),
        .rx_done   (done1),
        .frame_err (err1)
    );

    uart_rx #(.DBIT(7), .SB_TICK(32)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .s_tick    (s_tick),
        .rx        (rx2),
        .dout      (dout2),
        .rx_done   (done2),
        .frame_err (err2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle tick every 4 clocks, changed on the falling edge.
    always @(negedge clk) begin
        tick_div <= tick_div + 2'd1;
        s_tick   <= (tick_div == 2'd3);
    end

    always @(negedge clk) begin
        if (done1) begin
            done1_cnt <= done1_cnt + 1;
            done1_cyc <= cyc;
        end
        if (err1) err1_cnt <= err1_cnt + 1;
        if (done2) begin
            done2_cnt <= done2_cnt + 1;
            done2_cyc <= cyc;
        end
        if (err2) err2_cnt <= err2_cnt + 1;
        if ((done1 && err1) || ((done1 || err1) && prev1)) viol <= viol + 1;
        if ((done2 && err2) || ((done2 || err2) && prev2)) viol <= viol + 1;
        prev1 <= done1 | err1;
        prev2 <= done2 | err2;
    end

    task automatic hold(input bit sel, input logic b, input int n);
        if (sel) rx2 = b;
        else rx1 = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] data, input int nbits,
                              input int nstop, input bit bad_stop);
        edge_cyc = cyc;
        hold(sel, 1'b0, 64);
        for (int i = 0; i < nbits; i++) hold(sel, data[i], 64);
        if (bad_stop) begin
            hold(sel, 1'b0, 48);
            hold(sel, 1'b1, 16);
        end else begin
            hold(sel, 1'b1, 64 * nstop);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (dout1 !== 8'h00) $display("FAIL reset_dout: got %h want 00", dout1);
        else n_pass++;
        n_checks++;
        if (done1 !== 1'b0) $display("FAIL reset_rx_done: got %b want 0", done1);
        else n_pass++;
        n_checks++;
        if (err1 !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", err1);
        else n_pass++;
        n_checks++;
        if (dout2 !== 7'h00) $display("FAIL reset_dout2: got %h want 00", dout2);
        else n_pass++;
        rst = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_single();
        int d0, e0;
        int unsigned lat;
        d0 = done1_cnt;
        e0 = err1_cnt;
        send_frame(1'b0, 8'hA5, 8, 1, 1'b0);
        repeat (4) @(negedge clk);
        lat = done1_cyc - edge_cyc;
        n_checks++;
        if (done1_cnt - d0 !== 1) $display("FAIL single_done_count: got %0d want 1", done1_cnt - d0);
        else n_pass++;
        n_checks++;
        if (dout1 !== 8'hA5) $display("FAIL single_dout: got %h want a5", dout1);
        else n_pass++;
        n_checks++;
        if (err1_cnt - e0 !== 0) $display("FAIL single_frame_err: got %0d want 0", err1_cnt - e0);
        else n_pass++;
        n_checks++;
        if (lat < 605 || lat > 615) $display("FAIL single_latency: got %0d want 605..615", lat);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int d0, e0;
        d0 = done1_cnt;
        e0 = err1_cnt;
        hold(1'b0, 1'b0, 12);
        hold(1'b0, 1'b1, 200);
        n_checks++;
        if (done1_cnt - d0 !== 0) $display("FAIL glitch_done: got %0d want 0", done1_cnt - d0);
        else n_pass++;
        n_checks++;
        if (err1_cnt - e0 !== 0) $display("FAIL glitch_err: got %0d want 0", err1_cnt - e0);
        else n_pass++;
        n_checks++;
        if (dout1 !== 8'hA5) $display("FAIL glitch_dout: got %h want a5", dout1);
        else n_pass++;
    endtask

    task automatic test_framing();
        int d0, e0;
        d0 = done1_cnt;
        e0 = err1_cnt;
        send_frame(1'b0, 8'h3C, 8, 1, 1'b1);
        repeat (100) @(negedge clk);
        n_checks++;
        if (err1_cnt - e0 !== 1) $display("FAIL framing_err_count: got %0d want 1", err1_cnt - e0);
        else n_pass++;
        n_checks++;
        if (done1_cnt - d0 !== 0) $display("FAIL framing_done: got %0d want 0", done1_cnt - d0);
        else n_pass++;
        n_checks++;
        if (dout1 !== 8'hA5) $display("FAIL framing_dout: got %h want a5", dout1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done1_cnt;
        send_frame(1'b0, 8'h00, 8, 1, 1'b0);
        n_checks++;
        if (dout1 !== 8'h00) $display("FAIL b2b_first_dout: got %h want 00", dout1);
        else n_pass++;
        send_frame(1'b0, 8'hFF, 8, 1, 1'b0);
        repeat (4) @(negedge clk);
        n_checks++;
        if (dout1 !== 8'hFF) $display("FAIL b2b_second_dout: got %h want ff", dout1);
        else n_pass++;
        n_checks++;
        if (done1_cnt - d0 !== 2) $display("FAIL b2b_done_count: got %0d want 2", done1_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int d0, e0;
        logic [7:0] v;
        v  = 8'h5A;
        d0 = done1_cnt;
        e0 = err1_cnt;
        hold(1'b0, 1'b0, 64);
        for (int i = 0; i < 4; i++) hold(1'b0, v[i], 64);
        hold(1'b0, v[4], 32);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_checks++;
        if (dout1 !== 8'h00) $display("FAIL midrst_dout: got %h want 00", dout1);
        else n_pass++;
        n_checks++;
        if ({done1, err1} !== 2'b00) $display("FAIL midrst_pulses: got %b want 00", {done1, err1});
        else n_pass++;
        hold(1'b0, 1'b1, 700);
        n_checks++;
        if ((done1_cnt - d0) + (err1_cnt - e0) !== 0)
            $display("FAIL midrst_no_pulse: got %0d want 0", (done1_cnt - d0) + (err1_cnt - e0));
        else n_pass++;
        send_frame(1'b0, 8'h81, 8, 1, 1'b0);
        repeat (4) @(negedge clk);
        n_checks++;
        if (dout1 !== 8'h81) $display("FAIL midrst_next_dout: got %h want 81", dout1);
        else n_pass++;
        n_checks++;
        if (done1_cnt - d0 !== 1) $display("FAIL midrst_next_done: got %0d want 1", done1_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_long_stop();
        int d0, e0;
        int unsigned lat;
        logic [7:0] v;
        v  = 8'h55;
        d0 = done2_cnt;
        e0 = err2_cnt;
        edge_cyc = cyc;
        hold(1'b1, 1'b0, 64);
        for (int i = 0; i < 7; i++) hold(1'b1, v[i], 64);
        hold(1'b1, 1'b1, 88);
        n_checks++;
        if (done2_cnt - d0 !== 0) $display("FAIL stop2_early_done: got %0d want 0", done2_cnt - d0);
        else n_pass++;
        hold(1'b1, 1'b1, 40);
        lat = done2_cyc - edge_cyc;
        n_checks++;
        if (done2_cnt - d0 !== 1) $display("FAIL stop2_done_count: got %0d want 1", done2_cnt - d0);
        else n_pass++;
        n_checks++;
        if (dout2 !== 7'h55) $display("FAIL stop2_dout: got %h want 55", dout2);
        else n_pass++;
        n_checks++;
        if (lat < 605 || lat > 615) $display("FAIL stop2_latency: got %0d want 605..615", lat);
        else n_pass++;
        hold(1'b1, 1'b1, 88);
        n_checks++;
        if (err2_cnt - e0 !== 0) $display("FAIL stop2_frame_err: got %0d want 0", err2_cnt - e0);
        else n_pass++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid();
        test_long_stop();
        n_checks++;
        if (viol !== 0) $display("FAIL pulse_protocol: got %0d violations want 0", viol);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
